softmax_norm: RTL

- Normalisation stage of the tree-based softmax approximation. Sits directly downstream of the RU and consumes its pow2-approx output (o_out1).
- Buffers one vector of N exponent values and accumulates their sum. Computes the reciprocal of the sum with a sequential restoring divider.
- Then streams out each buffered value multiplied by the reciprocal, i.e. the approximate softmax probability, in arrival order.

---
 rtl/softmax_norm.sv | 131 +++++++++++++
 1 files changed

// File: rtl/softmax_norm.sv
// Softmax normalisation stage: buffers one vector of pow2-approx values, divides
// 2^(2*FRAC) by their sum to form a reciprocal, then streams out value * reciprocal.
module softmax_norm #(
    parameter int N    = 8,
    parameter int DW   = 16,
    parameter int FRAC = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_valid,
    input  logic [DW-1:0] i_in,
    output logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_out,
    output logic          o_last
);
    localparam int CW  = $clog2(N);
    localparam int SW  = DW + CW;
    localparam int QW  = 2 * FRAC + 1;
    localparam int RW  = 2 * FRAC;
    localparam int PW  = 2 * DW;
    localparam int DCW = $clog2(QW);

    typedef enum logic [1:0] {ACC, DIV, OUT} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   idx;
    logic [DCW-1:0]  div_cnt;
    logic [SW-1:0]   sum;
    logic [RW-1:0]   rem;
    logic [QW-1:0]   quot;
    logic [DW-1:0]   recip;
    logic [DW-1:0]   vbuf [N];

    logic            accept;
    logic [RW:0]     trial;
    logic [RW:0]     sum_ext;
    logic [RW:0]     diff;
    logic            q_bit;
    logic [RW-1:0]   rem_next;
    logic [QW-1:0]   quot_next;
    logic [PW-1:0]   prod;

    function automatic logic [DW-1:0] sat_recip(input logic [QW-1:0] q, input logic zero);
        if (zero || (q >> DW) != '0)
            return '1;
        return q[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sat_out(input logic [PW-1:0] p);
        logic [PW-FRAC-1:0] s;
        s = p[PW-1:FRAC];
        if (s[PW-FRAC-1:DW-1] != '0)
            return {1'b0, {(DW-1){1'b1}}};
        return s[DW-1:0];
    endfunction

    assign o_ready = (state == ACC);
    assign accept  = i_en && i_valid && o_ready;

    // Numerator 2^(2*FRAC) has a single set bit, shifted in on the first iteration.
    assign trial     = {rem, (div_cnt == '0)};
    assign sum_ext   = (RW+1)'(sum);
    assign diff      = trial - sum_ext;
    assign q_bit     = (trial >= sum_ext);
    assign rem_next  = q_bit ? diff[RW-1:0] : trial[RW-1:0];
    assign quot_next = {quot[QW-2:0], q_bit};

    assign prod = PW'(vbuf[idx]) * PW'(recip);

    always_ff @(posedge i_clk) begin
        if (accept)
            vbuf[count] <= i_in;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ACC;
            count   <= '0;
            idx     <= '0;
            div_cnt <= '0;
            sum     <= '0;
            rem     <= '0;
            quot    <= '0;
            recip   <= '0;
            o_valid <= 1'b0;
            o_out   <= '0;
            o_last  <= 1'b0;
        end else if (i_en) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            case (state)
                ACC: begin
                    if (i_valid) begin
                        sum   <= sum + SW'(i_in);
                        count <= count + CW'(1);
                        if (count == CW'(N-1)) begin
                            state   <= DIV;
                            div_cnt <= '0;
                            rem     <= '0;
                            quot    <= '0;
                        end
                    end
                end
                DIV: begin
                    rem     <= rem_next;
                    quot    <= quot_next;
                    div_cnt <= div_cnt + DCW'(1);
                    if (div_cnt == DCW'(QW-1)) begin
                        recip <= sat_recip(quot_next, sum == '0);
                        idx   <= '0;
                        state <= OUT;
                    end
                end
                OUT: begin
                    o_valid <= 1'b1;
                    o_out   <= sat_out(prod);
                    o_last  <= (idx == CW'(N-1));
                    idx     <= idx + CW'(1);
                    if (idx == CW'(N-1)) begin
                        sum   <= '0;
                        state <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule
